// File: rtl/ring_osc_entropy.sv
// Purpose: sample a free-running ring oscillator, Von Neumann debias it into WIDTH-bit random words, supervise for a stuck oscillator.
// Latency: osc_in reaches logic after SYNC_STAGES flops; a word is presented the cycle after the shifter fills; osc_en lags enable by 1 cycle.
// Backpressure: one-entry holding register; when it is occupied and not popped, a full shifter stalls and sample strobes are dropped.
// Optional build: define FREQ_METER_EN to enable the oscillator frequency meter driving osc_count (otherwise osc_count is tied 0).
module ring_osc_entropy #(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int SAMPLE_DIV    = 16,
    parameter int WARMUP_CYCLES = 256,
    parameter int STUCK_CYCLES  = 1024,
    parameter int GATE_CYCLES   = 65536
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             enable,
    input  logic             osc_in,
    output logic             osc_en,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             osc_stuck,
    output logic [31:0]      osc_count
);

    localparam int WARM_W  = $clog2(WARMUP_CYCLES + 1);
    localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);
    localparam int DIV_W   = $clog2(SAMPLE_DIV + 1);
    localparam int CNT_W   = $clog2(WIDTH + 1);

    if (WIDTH < 2 || SYNC_STAGES < 2 || SAMPLE_DIV < 1 || WARMUP_CYCLES < 1 ||
        STUCK_CYCLES < 1 || GATE_CYCLES < 2) begin : g_bad_param
        $error("ring_osc_entropy: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_STUCK} state_t;

    state_t               state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 osc_s, osc_prev, osc_chg;
    logic [WARM_W-1:0]    warm_cnt;
    logic [STUCK_W-1:0]   stuck_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [WIDTH-1:0]     shifter;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 pair_vld, pair_bit;
    logic                 active, stuck_timeout, warm_done, strobe;
    logic                 full, load, stall, pop, take, new_bit_vld, clr_shift;

    assign osc_s         = sync_q[SYNC_STAGES-1];
    assign osc_chg       = osc_s ^ osc_prev;
    assign active        = (state == S_WARMUP) || (state == S_COLLECT);
    assign stuck_timeout = active && !osc_chg && (stuck_cnt == STUCK_W'(STUCK_CYCLES - 1));
    assign warm_done     = (warm_cnt == WARM_W'(WARMUP_CYCLES - 1));
    assign strobe        = (state == S_COLLECT) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign full          = (bit_cnt == CNT_W'(WIDTH));
    assign stall         = full && rnd_valid && !rnd_ready;
    assign load          = full && (!rnd_valid || rnd_ready);
    assign pop           = rnd_valid && rnd_ready;
    assign take          = strobe && !stall;
    // a completed pair with differing samples yields the first sample as the bit
    assign new_bit_vld   = take && pair_vld && (pair_bit != osc_s);
    assign clr_shift     = (state == S_STUCK) || stuck_timeout;

    // Synchronise the asynchronous oscillator and keep the previous synced value for edge detection
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sync_q   <= '0;
            osc_prev <= 1'b0;
            osc_en   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], osc_in};
            osc_prev <= osc_s;
            osc_en   <= enable;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // FSM next state; disable overrides everything
    always_comb begin
        state_nxt = state;
        osc_stuck = (state == S_STUCK);
        case (state)
            S_IDLE:    if (enable) state_nxt = S_WARMUP;
            S_WARMUP:  if (stuck_timeout) state_nxt = S_STUCK;
                       else if (warm_done) state_nxt = S_COLLECT;
            S_COLLECT: if (stuck_timeout) state_nxt = S_STUCK;
            S_STUCK:   if (osc_chg) state_nxt = S_WARMUP;
            default:   state_nxt = S_IDLE;
        endcase
        if (!enable) state_nxt = S_IDLE;
    end

    // Warmup, stuck-supervision and sample-divider counters
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            warm_cnt  <= '0;
            stuck_cnt <= '0;
            div_cnt   <= '0;
        end else begin
            warm_cnt  <= (state == S_WARMUP) ? warm_cnt + WARM_W'(1) : '0;
            stuck_cnt <= (active && !osc_chg) ? stuck_cnt + STUCK_W'(1) : '0;
            if (state == S_COLLECT)
                div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
            else
                div_cnt <= '0;
        end
    end

    // Output holding register; rnd_data survives disable so software can still read the last word
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
        end else if (!enable) begin
            rnd_valid <= 1'b0;
        end else if (load && !clr_shift) begin
            rnd_valid <= 1'b1;
            rnd_data  <= shifter;
        end else if (pop) begin
            rnd_valid <= 1'b0;
        end
    end

    // Pair tracking and bit shifter; a bit arriving in the load cycle starts the next word
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            shifter  <= '0;
            bit_cnt  <= '0;
            pair_vld <= 1'b0;
            pair_bit <= 1'b0;
        end else if (!enable || clr_shift) begin
            shifter  <= '0;
            bit_cnt  <= '0;
            pair_vld <= 1'b0;
        end else begin
            if (stall) begin
                pair_vld <= 1'b0;
            end else if (take) begin
                pair_vld <= !pair_vld;
                if (!pair_vld) pair_bit <= osc_s;
            end
            if (load) begin
                shifter <= {{(WIDTH-1){1'b0}}, pair_bit};
                bit_cnt <= new_bit_vld ? CNT_W'(1) : '0;
            end else if (new_bit_vld) begin
                shifter <= {shifter[WIDTH-2:0], pair_bit};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef FREQ_METER_EN
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);

    logic [GATE_W-1:0] gate_cnt;
    logic [31:0]       edge_cnt;
    logic [31:0]       count_q;
    logic              rise;

    assign rise      = osc_s && !osc_prev;
    assign osc_count = count_q;

    // Gate window: publish the rising-edge count at each wrap, restart counting including this cycle's edge
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            count_q  <= '0;
        end else if (!enable) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (gate_cnt == GATE_W'(GATE_CYCLES - 1)) begin
            gate_cnt <= '0;
            count_q  <= edge_cnt;
            edge_cnt <= {31'd0, rise};
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            if (rise && edge_cnt != 32'hFFFF_FFFF) edge_cnt <= edge_cnt + 32'd1;
        end
    end
`else
    assign osc_count = 32'd0;
`endif

endmodule

// File: tb/tb_ring_osc_entropy.sv
// Directed bench: oscillator samples, ready and enable are scheduled per clock edge from tables built up front;
// every word expected to be popped is queued when scheduled and a monitor checks pops in order.
// S(e) is the synced oscillator value the DUT sees at edge e (osc_in is driven three edges earlier).
module tb_ring_osc_entropy;

    localparam int W     = 8;
    localparam int NEDGE = 3500;
    localparam int NTAB  = 3600;

    logic         clk = 1'b0;
    logic         resetq, enable, osc_in, rnd_ready;
    logic         osc_en, rnd_valid, osc_stuck;
    logic [W-1:0] rnd_data;
    logic [31:0]  osc_count;

    bit           samp [NTAB];
    bit           rdy  [NTAB];
    bit           en   [NTAB];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    ring_osc_entropy #(
        .WIDTH(W), .SYNC_STAGES(2), .SAMPLE_DIV(1), .WARMUP_CYCLES(16),
        .STUCK_CYCLES(64), .GATE_CYCLES(1024)
    ) dut (
        .clk(clk), .resetq(resetq), .enable(enable), .osc_in(osc_in),
        .osc_en(osc_en), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready), .osc_stuck(osc_stuck), .osc_count(osc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Each word bit b becomes the sample pair (b, !b), MSB first
    task automatic add_word(input int e0, input logic [W-1:0] w, input bit scored);
        for (int i = 0; i < W; i++) begin
            samp[e0 + 2*i]     = w[W-1-i];
            samp[e0 + 2*i + 1] = !w[W-1-i];
        end
        if (scored) exp_q.push_back(w);
    endtask

    // Scoreboard monitor: every transfer must match the next queued word
    always @(negedge clk) begin
        if (resetq && rnd_valid && rnd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_word: unexpected word %0h popped, none expected", rnd_data);
            end else begin
                logic [W-1:0] want;
                want = exp_q.pop_front();
                if (rnd_data !== want) begin
                    n_fail++;
                    $display("FAIL sb_word: got %0h, expected %0h", rnd_data, want);
                end
            end
        end
    end

    initial begin
        resetq = 1'b0; enable = 1'b0; osc_in = 1'b0; rnd_ready = 1'b0;

        for (int e = 0; e < NTAB; e++) begin
            samp[e] = 1'b0;
            rdy[e]  = (e <= 50) || (e == 97) || (e >= 110 && e <= 283) || (e >= 300);
            en[e]   = !(e >= 290 && e <= 299);
        end
        // warmup ends after edge 16; strobes from edge 17, one every edge
        add_word(17, 8'h55, 1'b1);
        add_word(33, 8'h55, 1'b1);
        add_word(49, 8'hA7, 1'b1);
        add_word(65, 8'h3C, 1'b1);
        // filler toggles every 2 samples; pairs restart at edge 97 and always see equal values
        for (int e = 81; e <= 150; e++) samp[e] = ((e - 81) >> 1) & 1;
        // oscillator frozen from edge 150; recovery edge at 250, 16 warmup edges, strobes from 267
        for (int e = 250; e <= 266; e++) samp[e] = 1'b1;
        add_word(267, 8'h96, 1'b0);
        add_word(283, 8'hF0, 1'b0);
        // re-enabled at edge 300: warmup through 316, strobes from 317
        add_word(317, 8'h3A, 1'b1);
        // period-8 square whose transitions fall on pair boundaries, so no bits result
        for (int e = 351; e < NTAB; e++) samp[e] = ((e - 351) >> 2) & 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_osc_en",    osc_en,    0);
        chk("reset_rnd_data",  rnd_data,  0);
        chk("reset_rnd_valid", rnd_valid, 0);
        chk("reset_osc_stuck", osc_stuck, 0);
        chk("reset_osc_count", osc_count, 0);

        @(posedge clk); #2;
        resetq = 1'b1; enable = en[0]; rnd_ready = rdy[0]; osc_in = samp[2];

        for (int k = 0; k < NEDGE; k++) begin
            @(posedge clk); #2;
            osc_in    = samp[k + 3];
            rnd_ready = rdy[k + 1];
            enable    = en[k + 1];
            @(negedge clk);
            // values below are those registered at edge k
            if (k == 0)   chk("osc_en_after_enable", osc_en, 1);
            if (k <= 32)  chk("valid_low_warmup", rnd_valid, 0);
            if (k == 33) begin
                chk("word0_valid", rnd_valid, 1);
                chk("word0_data",  rnd_data,  32'h55);
            end
            if (k == 34)  chk("valid_pulse_end", rnd_valid, 0);
            if (k == 70 || k == 90) begin
                chk("stall_valid_held", rnd_valid, 1);
                chk("stall_data_held",  rnd_data,  32'hA7);
            end
            if (k == 97 || k == 109) begin
                chk("second_word_valid", rnd_valid, 1);
                chk("second_word_data",  rnd_data,  32'h3C);
            end
            if (k == 110) chk("drained_valid", rnd_valid, 0);
            if (k == 205) chk("stuck_not_yet", osc_stuck, 0);
            if (k == 220 || k == 249) chk("stuck_flag", osc_stuck, 1);
            if (k == 250) chk("stuck_recovered", osc_stuck, 0);
            if (k == 282) chk("recovery_warmup_no_word", rnd_valid, 0);
            if (k == 283) begin
                chk("recovery_word_valid", rnd_valid, 1);
                chk("recovery_word_data",  rnd_data,  32'h96);
            end
            if (k == 290) begin
                chk("disable_osc_en",    osc_en,    0);
                chk("disable_valid",     rnd_valid, 0);
                chk("disable_data_kept", rnd_data,  32'h96);
            end
            if (k == 300) chk("reenable_osc_en", osc_en, 1);
            if (k == 332) chk("reenable_warmup_no_word", rnd_valid, 0);
            if (k == 333) begin
                chk("reenable_word_valid", rnd_valid, 1);
                chk("reenable_word_data",  rnd_data,  32'h3A);
            end
            if (k == 2400 || k == 3400) begin
                chk("square_no_stuck", osc_stuck, 0);
`ifdef FREQ_METER_EN
                n_checks++;
                if (osc_count < 32'd127 || osc_count > 32'd129) begin
                    n_fail++;
                    $display("FAIL osc_count: got %0d, expected 127..129", osc_count);
                end
`else
                chk("osc_count_tied", osc_count, 0);
`endif
            end
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
